// File: rtl/mem_stage.sv
// mem_stage -- MIPS pipeline MEM stage between the EX/MEM register and the data RAM.
//   Drives RAM ce/we/addr/sel/data combinationally, formats store bytes,
//   extracts and extends load data, flags misaligned accesses, owns the LL/SC
//   link bit and registers the writeback result into MEM/WB.
// Ports:
//   clk, rst (async, active-high)      clocking / reset
//   stall_i, flush_i, llbit_clr_i      pipeline control
//   wd_i, wreg_i, wdata_i              writeback request from EX/MEM
//   mem_op_i, mem_addr_i, mem_wdata_i  memory operation, address, store data
//   ram_data_i                         RAM combinational read data
//   ram_ce_o, ram_we_o, ram_addr_o,
//   ram_sel_o, ram_data_o              RAM interface (big-endian lanes)
//   adel_o, ades_o, badvaddr_o         address error reporting
//   wb_wd_o, wb_wreg_o, wb_wdata_o     MEM/WB register outputs
//   llbit_o                            current link bit
// Configuration: define LLSC_EN to implement LL/SC and the LLbit register;
//   otherwise ops 9/10 decode as NONE and llbit_o is tied low.
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              llbit_clr_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        mem_op_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [3:0]        ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [ADDR_W-1:0] badvaddr_o,
  output logic [4:0]        wb_wd_o,
  output logic              wb_wreg_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic              llbit_o
);

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8,
    OP_LL   = 4'd9,
    OP_SC   = 4'd10
  } mem_op_e;

  logic        is_ld, is_st, is_ll, is_sc, ld_sgn;
  logic        sz_b, sz_h, sz_w, misalign;
  logic [1:0]  off;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] ld_data;
  logic        llbit_q;

  logic [4:0]  wb_wd_q, wb_wd_d;
  logic        wb_wreg_q, wb_wreg_d;
  logic [31:0] wb_wdata_q, wb_wdata_d;

  assign off        = mem_addr_i[1:0];
  assign ram_addr_o = mem_addr_i;
  assign badvaddr_o = mem_addr_i;

  always_comb begin
    is_ld  = 1'b0;
    is_st  = 1'b0;
    is_ll  = 1'b0;
    is_sc  = 1'b0;
    ld_sgn = 1'b0;
    sz_b   = 1'b0;
    sz_h   = 1'b0;
    sz_w   = 1'b0;
    case (mem_op_i)
      OP_LB:  begin is_ld = 1'b1; sz_b = 1'b1; ld_sgn = 1'b1; end
      OP_LBU: begin is_ld = 1'b1; sz_b = 1'b1; end
      OP_LH:  begin is_ld = 1'b1; sz_h = 1'b1; ld_sgn = 1'b1; end
      OP_LHU: begin is_ld = 1'b1; sz_h = 1'b1; end
      OP_LW:  begin is_ld = 1'b1; sz_w = 1'b1; end
      OP_SB:  begin is_st = 1'b1; sz_b = 1'b1; end
      OP_SH:  begin is_st = 1'b1; sz_h = 1'b1; end
      OP_SW:  begin is_st = 1'b1; sz_w = 1'b1; end
`ifdef LLSC_EN
      OP_LL:  begin is_ld = 1'b1; sz_w = 1'b1; is_ll = 1'b1; end
      OP_SC:  begin is_st = 1'b1; sz_w = 1'b1; is_sc = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign misalign = (sz_h & off[0]) | (sz_w & (off != 2'b00));
  assign adel_o   = is_ld & misalign;
  assign ades_o   = is_st & misalign;
  assign ram_ce_o = (is_ld | is_st) & ~misalign;
  // A failed SC (link lost) must not reach memory.
  assign ram_we_o = is_st & ~misalign & ~stall_i & ~flush_i & (~is_sc | llbit_q);

  always_comb begin
    ram_sel_o  = '0;
    ram_data_o = '0;
    if (sz_b)      ram_sel_o = 4'b1000 >> off;
    else if (sz_h) ram_sel_o = off[1] ? 4'b0011 : 4'b1100;
    else if (sz_w) ram_sel_o = 4'b1111;
    if (is_st) begin
      if (sz_b)      ram_data_o = {4{mem_wdata_i[7:0]}};
      else if (sz_h) ram_data_o = {2{mem_wdata_i[15:0]}};
      else           ram_data_o = mem_wdata_i;
    end
  end

  always_comb begin
    case (off)
      2'd0:    byte_lane = ram_data_i[31:24];
      2'd1:    byte_lane = ram_data_i[23:16];
      2'd2:    byte_lane = ram_data_i[15:8];
      default: byte_lane = ram_data_i[7:0];
    endcase
    half_lane = off[1] ? ram_data_i[15:0] : ram_data_i[31:16];
    if (sz_b)      ld_data = {{24{ld_sgn & byte_lane[7]}}, byte_lane};
    else if (sz_h) ld_data = {{16{ld_sgn & half_lane[15]}}, half_lane};
    else           ld_data = ram_data_i;
  end

  always_comb begin
    wb_wd_d    = wd_i;
    wb_wreg_d  = wreg_i & ~misalign;
    wb_wdata_d = wdata_i;
    if (is_ld)      wb_wdata_d = ld_data;
    else if (is_sc) wb_wdata_d = {31'd0, llbit_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_wd_q    <= '0;
      wb_wreg_q  <= 1'b0;
      wb_wdata_q <= '0;
    end else if (flush_i) begin
      wb_wd_q    <= '0;
      wb_wreg_q  <= 1'b0;
      wb_wdata_q <= '0;
    end else if (!stall_i) begin
      wb_wd_q    <= wb_wd_d;
      wb_wreg_q  <= wb_wreg_d;
      wb_wdata_q <= wb_wdata_d;
    end
  end

  assign wb_wd_o    = wb_wd_q;
  assign wb_wreg_o  = wb_wreg_q;
  assign wb_wdata_o = wb_wdata_q;

`ifdef LLSC_EN
  logic llbit_d;

  // Clear request wins even in a stalled/flushed cycle (it accompanies exceptions).
  always_comb begin
    llbit_d = llbit_q;
    if (llbit_clr_i) begin
      llbit_d = 1'b0;
    end else if (!stall_i && !flush_i && !misalign) begin
      if (is_sc)      llbit_d = 1'b0;
      else if (is_ll) llbit_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) llbit_q <= 1'b0;
    else     llbit_q <= llbit_d;
  end

  assign llbit_o = llbit_q;
`else
  logic unused_llsc;

  assign llbit_q     = 1'b0;
  assign llbit_o     = 1'b0;
  assign unused_llsc = llbit_clr_i | is_ll;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

`ifdef LLSC_EN
  localparam bit LLSC = 1'b1;
`else
  localparam bit LLSC = 1'b0;
`endif

  logic        clk, rst, stall_i, flush_i, llbit_clr_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i, mem_wdata_i, ram_data_i;
  logic        ram_ce_o, ram_we_o, adel_o, ades_o, wb_wreg_o, llbit_o;
  logic [31:0] ram_addr_o, ram_data_o, badvaddr_o, wb_wdata_o;
  logic [3:0]  ram_sel_o;
  logic [4:0]  wb_wd_o;

  int tests, fails;

  // Bench RAM: written from the model's expectations, not from DUT outputs.
  logic [31:0] mem [16];
  assign ram_data_i = mem[mem_addr_i[5:2]];

  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .llbit_clr_i(llbit_clr_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .ram_data_i(ram_data_i), .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o),
    .adel_o(adel_o), .ades_o(ades_o), .badvaddr_o(badvaddr_o),
    .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o), .wb_wdata_o(wb_wdata_o),
    .llbit_o(llbit_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state (current) and next-state computed per cycle.
  logic [4:0]  m_wd, n_wd;
  logic        m_wreg, n_wreg, m_ll, n_ll, m_wdc, n_wdc, n_we;
  logic [31:0] m_wdata, n_wdata, n_dat;
  logic [3:0]  n_sel, n_idx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] r,
                       input logic s, input logic f, input logic c);
    mem_op_i = o; mem_addr_i = a; mem_wdata_i = r;
    stall_i = s; flush_i = f; llbit_clr_i = c;
  endtask

  task automatic mid();
    int size, off;
    bit ld, st, sgn, llop, scop, al, ce, we;
    logic [63:0] mask, v;
    logic [31:0] esel, edat, ldv;
    #2;
    size = 0; ld = 0; st = 0; sgn = 0; llop = 0; scop = 0;
    case (mem_op_i)
      4'd1:  begin ld = 1; size = 1; sgn = 1; end
      4'd2:  begin ld = 1; size = 1; end
      4'd3:  begin ld = 1; size = 2; sgn = 1; end
      4'd4:  begin ld = 1; size = 2; end
      4'd5:  begin ld = 1; size = 4; end
      4'd6:  begin st = 1; size = 1; end
      4'd7:  begin st = 1; size = 2; end
      4'd8:  begin st = 1; size = 4; end
      4'd9:  begin ld = LLSC; llop = LLSC; size = LLSC ? 4 : 0; end
      4'd10: begin st = LLSC; scop = LLSC; size = LLSC ? 4 : 0; end
      default: ;
    endcase
    off  = int'(mem_addr_i & 32'd3);
    al   = (size == 0) || (off % size == 0);
    esel = 0; ldv = 0;
    if (size != 0 && al) esel = ((1 << size) - 1) << (4 - size - off);
    case (size)
      1:       edat = (mem_wdata_i & 32'hFF) * 32'h0101_0101;
      2:       edat = (mem_wdata_i & 32'hFFFF) * 32'h0001_0001;
      4:       edat = mem_wdata_i;
      default: edat = 0;
    endcase
    if (ld && al) begin
      mask = (64'd1 << (8 * size)) - 64'd1;
      v = ({32'd0, ram_data_i} >> (8 * (4 - size - off))) & mask;
      if (sgn && v[8*size-1]) v = v | ~mask;
      ldv = v[31:0];
    end
    ce = (ld || st) && al;
    we = st && al && !stall_i && !flush_i && (!scop || m_ll);
    chk("ram_addr_o", ram_addr_o, mem_addr_i);
    chk("badvaddr_o", badvaddr_o, mem_addr_i);
    chk("adel_o", 32'(adel_o), 32'(ld && !al));
    chk("ades_o", 32'(ades_o), 32'(st && !al));
    chk("ram_we_o", 32'(ram_we_o), 32'(we));
    if (!(scop && al && !m_ll)) chk("ram_ce_o", 32'(ram_ce_o), 32'(ce));
    if (size == 0) begin
      chk("ram_sel_o none", 32'(ram_sel_o), 32'd0);
      chk("ram_data_o none", ram_data_o, 32'd0);
    end else if (al) begin
      chk("ram_sel_o", 32'(ram_sel_o), esel);
      if (st) chk("ram_data_o", ram_data_o, edat);
    end
    if (flush_i) begin
      n_wd = 0; n_wreg = 0; n_wdata = 0; n_wdc = 0;
    end else if (stall_i) begin
      n_wd = m_wd; n_wreg = m_wreg; n_wdata = m_wdata; n_wdc = m_wdc;
    end else begin
      n_wd = wd_i; n_wreg = wreg_i && al; n_wdc = !al;
      n_wdata = ld ? ldv : (scop ? 32'(m_ll) : wdata_i);
    end
    n_ll = m_ll;
    if (llbit_clr_i) n_ll = 0;
    else if (!stall_i && !flush_i && al) begin
      if (scop) n_ll = 0;
      else if (llop) n_ll = 1;
    end
    n_we = we; n_sel = esel[3:0]; n_dat = edat; n_idx = mem_addr_i[5:2];
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
    if (n_we)
      for (int k = 0; k < 4; k++)
        if (n_sel[k]) mem[n_idx][8*k +: 8] = n_dat[8*k +: 8];
    m_wd = n_wd; m_wreg = n_wreg; m_wdata = n_wdata; m_wdc = n_wdc; m_ll = n_ll;
    chk("wb_wd_o", 32'(wb_wd_o), 32'(m_wd));
    chk("wb_wreg_o", 32'(wb_wreg_o), 32'(m_wreg));
    if (!m_wdc) chk("wb_wdata_o", wb_wdata_o, m_wdata);
    chk("llbit_o", 32'(llbit_o), 32'(m_ll));
  endtask

  task automatic model_reset();
    m_wd = 0; m_wreg = 0; m_wdata = 0; m_wdc = 0; m_ll = 0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr, rt;
    logic [3:0]  sel;
    bit          ce, we, err;
    logic [31:0] dout;
    bit          chkd, chks;
    logic [31:0] wb;
    bit          wreg, chkwb;
  } vec_t;

  vec_t tbl [17];

  initial begin
    tests = 0; fails = 0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    model_reset();

    // Reset: registered outputs zero while rst is high, comb outputs follow inputs.
    rst = 1'b1;
    drive(4'd5, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("reset wb_wd_o", 32'(wb_wd_o), 32'd0);
    chk("reset wb_wreg_o", 32'(wb_wreg_o), 32'd0);
    chk("reset wb_wdata_o", wb_wdata_o, 32'd0);
    chk("reset llbit_o", 32'(llbit_o), 32'd0);
    chk("reset ram_addr_o", ram_addr_o, 32'h10);
    rst = 1'b0;

    //           op     addr     rt            sel      ce we err dout         chkd chks wb            wreg chkwb
    tbl[0]  = '{4'd8,  32'h10, 32'h11223344, 4'b1111, 1, 1, 0, 32'h11223344, 1, 1, 32'hDEAD0000, 1, 1};
    tbl[1]  = '{4'd1,  32'h11, 32'h0,        4'b0100, 1, 0, 0, 32'h0,        0, 1, 32'h00000022, 1, 1};
    tbl[2]  = '{4'd6,  32'h13, 32'h000000AB, 4'b0001, 1, 1, 0, 32'hABABABAB, 1, 1, 32'hDEAD0000, 1, 1};
    tbl[3]  = '{4'd1,  32'h13, 32'h0,        4'b0001, 1, 0, 0, 32'h0,        0, 1, 32'hFFFFFFAB, 1, 1};
    tbl[4]  = '{4'd2,  32'h13, 32'h0,        4'b0001, 1, 0, 0, 32'h0,        0, 1, 32'h000000AB, 1, 1};
    tbl[5]  = '{4'd7,  32'h12, 32'h12348001, 4'b0011, 1, 1, 0, 32'h80018001, 1, 1, 32'hDEAD0000, 1, 1};
    tbl[6]  = '{4'd3,  32'h12, 32'h0,        4'b0011, 1, 0, 0, 32'h0,        0, 1, 32'hFFFF8001, 1, 1};
    tbl[7]  = '{4'd4,  32'h12, 32'h0,        4'b0011, 1, 0, 0, 32'h0,        0, 1, 32'h00008001, 1, 1};
    tbl[8]  = '{4'd3,  32'h10, 32'h0,        4'b1100, 1, 0, 0, 32'h0,        0, 1, 32'h00001122, 1, 1};
    tbl[9]  = '{4'd5,  32'h10, 32'h0,        4'b1111, 1, 0, 0, 32'h0,        0, 1, 32'h11228001, 1, 1};
    tbl[10] = '{4'd5,  32'h06, 32'h0,        4'b0000, 0, 0, 1, 32'h0,        0, 0, 32'h0,        0, 0};
    tbl[11] = '{4'd7,  32'h11, 32'h5555,     4'b0000, 0, 0, 1, 32'h0,        0, 0, 32'h0,        0, 0};
    tbl[12] = '{4'd8,  32'h05, 32'h5555,     4'b0000, 0, 0, 1, 32'h0,        0, 0, 32'h0,        0, 0};
    tbl[13] = '{4'd0,  32'h10, 32'hFFFF,     4'b0000, 0, 0, 0, 32'h0,        1, 1, 32'hDEAD0000, 1, 1};
    tbl[14] = '{4'd13, 32'h14, 32'hFFFF,     4'b0000, 0, 0, 0, 32'h0,        1, 1, 32'hDEAD0000, 1, 1};
    tbl[15] = '{4'd6,  32'h10, 32'h0000005A, 4'b1000, 1, 1, 0, 32'h5A5A5A5A, 1, 1, 32'hDEAD0000, 1, 1};
    tbl[16] = '{4'd1,  32'h10, 32'h0,        4'b1000, 1, 0, 0, 32'h0,        0, 1, 32'h0000005A, 1, 1};

    wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hDEAD0000;
    for (int unsigned i = 0; i < 17; i++) begin
      drive(tbl[i].op, tbl[i].addr, tbl[i].rt, 1'b0, 1'b0, 1'b0);
      mid();
      chk($sformatf("tbl%0d ce", i), 32'(ram_ce_o), 32'(tbl[i].ce));
      chk($sformatf("tbl%0d we", i), 32'(ram_we_o), 32'(tbl[i].we));
      chk($sformatf("tbl%0d err", i), 32'(adel_o | ades_o), 32'(tbl[i].err));
      if (tbl[i].chks) chk($sformatf("tbl%0d sel", i), 32'(ram_sel_o), 32'(tbl[i].sel));
      if (tbl[i].chkd) chk($sformatf("tbl%0d dout", i), ram_data_o, tbl[i].dout);
      fin();
      chk($sformatf("tbl%0d wreg", i), 32'(wb_wreg_o), 32'(tbl[i].wreg));
      if (tbl[i].chkwb) chk($sformatf("tbl%0d wb", i), wb_wdata_o, tbl[i].wb);
    end

    // Store held by a 3-cycle stall, then released.
    wd_i = 5'd3; wdata_i = 32'h12345678;
    drive(4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    mid(); fin();
    chk("pre-stall wb", wb_wdata_o, 32'h12345678);
    wdata_i = 32'hCAFE0001;
    for (int unsigned i = 0; i < 3; i++) begin
      drive(4'd8, 32'h20, 32'h55, 1'b1, 1'b0, 1'b0);
      mid();
      chk("stalled we", 32'(ram_we_o), 32'd0);
      fin();
      chk("stalled wb held", wb_wdata_o, 32'h12345678);
    end
    drive(4'd8, 32'h20, 32'h55, 1'b0, 1'b0, 1'b0);
    mid();
    chk("release we", 32'(ram_we_o), 32'd1);
    fin();
    chk("release wb", wb_wdata_o, 32'hCAFE0001);

    // Flush beats stall.
    drive(4'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    mid(); fin();
    chk("flush wd", 32'(wb_wd_o), 32'd0);
    chk("flush wreg", 32'(wb_wreg_o), 32'd0);
    chk("flush wdata", wb_wdata_o, 32'd0);

    wd_i = 5'd2; wdata_i = 32'h0BAD0BAD;
`ifdef LLSC_EN
    drive(4'd9, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
    mid(); fin();
    chk("LL llbit", 32'(llbit_o), 32'd1);
    chk("LL data", wb_wdata_o, 32'h55);
    drive(4'd10, 32'h20, 32'h77, 1'b0, 1'b0, 1'b0);
    mid();
    chk("SC ok we", 32'(ram_we_o), 32'd1);
    fin();
    chk("SC ok rt", wb_wdata_o, 32'd1);
    chk("SC ok llbit", 32'(llbit_o), 32'd0);
    drive(4'd9, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
    mid(); fin();
    drive(4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    mid(); fin();
    chk("clr llbit", 32'(llbit_o), 32'd0);
    drive(4'd10, 32'h20, 32'h99, 1'b0, 1'b0, 1'b0);
    mid();
    chk("SC fail we", 32'(ram_we_o), 32'd0);
    fin();
    chk("SC fail rt", wb_wdata_o, 32'd0);
    drive(4'd5, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
    mid(); fin();
    chk("post-SC mem", wb_wdata_o, 32'h77);
    drive(4'd9, 32'h24, 32'h0, 1'b0, 1'b0, 1'b0);
`else
    drive(4'd9, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
    mid();
    chk("op9 ce", 32'(ram_ce_o), 32'd0);
    fin();
    chk("op9 wb", wb_wdata_o, 32'h0BAD0BAD);
    drive(4'd10, 32'h20, 32'h99, 1'b0, 1'b0, 1'b1);
    mid();
    chk("op10 we", 32'(ram_we_o), 32'd0);
    fin();
    chk("op10 llbit", 32'(llbit_o), 32'd0);
    drive(4'd5, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
`endif
    mid(); fin();

    // Asynchronous reset mid-cycle.
    drive(4'd5, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst wd", 32'(wb_wd_o), 32'd0);
    chk("async rst wreg", 32'(wb_wreg_o), 32'd0);
    chk("async rst wdata", wb_wdata_o, 32'd0);
    chk("async rst llbit", 32'(llbit_o), 32'd0);
    chk("async rst addr", ram_addr_o, 32'h20);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Randomized traffic against the reference model.
    for (int unsigned i = 0; i < 400; i++) begin
      wd_i = 5'($urandom); wreg_i = 1'($urandom); wdata_i = $urandom;
      drive(4'($urandom_range(0, 15)), 32'($urandom_range(0, 63)), $urandom,
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 15) == 0);
      mid(); fin();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
